// File: rtl/clap_pattern_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clap_pattern_ctrl_pkg
//   Shared definitions for the clap pattern sequencer:
//   - FSM state encodings (IDLE / REFRACT / WAIT_GAP / EMIT)
//   - command codes carried on cmd_code_o
//   - default timing and counter-width parameters
//   - timer width helper used to size the shared down-counter
//   No ports (package).
// -----------------------------------------------------------------------------
package clap_pattern_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REFRACT  = 2'd1,
      ST_WAIT_GAP = 2'd2,
      ST_EMIT     = 2'd3
   } state_t;

   // Command codes double as the group size (number of claps in the group).
   localparam logic [1:0] CMD_NONE   = 2'd0;
   localparam logic [1:0] CMD_SINGLE = 2'd1;
   localparam logic [1:0] CMD_DOUBLE = 2'd2;
   localparam logic [1:0] CMD_TRIPLE = 2'd3;

   // 50 ms refractory and 400 ms closing gap at 100 MHz.
   localparam int REFRACT_CYC_DFLT = 5_000_000;
   localparam int GAP_CYC_DFLT     = 40_000_000;
   localparam int CNT_W_DFLT       = 32;

   // Width of a down-counter that must hold max(a,b)-1; never narrower than 1 bit.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      if (m < 2) begin
         return 1;
      end else begin
         return $clog2(m);
      end
   endfunction

endpackage

// File: rtl/clap_pattern_ctrl_timer.sv
// -----------------------------------------------------------------------------
// clap_pattern_ctrl_timer
//   Loadable down-counter shared by the refractory and gap phases.
//   Ports:
//     clk_i   in  1   system clock
//     rst_i   in  1   asynchronous active-high reset (counter -> 0)
//     load_i  in  1   load val_i this cycle (has priority over counting)
//     val_i   in  W   value to load; zero_o asserts val_i+1 cycles after load
//     zero_o  out 1   counter currently at zero (counter saturates at zero)
// -----------------------------------------------------------------------------
module clap_pattern_ctrl_timer
   import clap_pattern_ctrl_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_r;

   // Load has priority; otherwise count down and hold at zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r <= '0;
      end else if (load_i) begin
         cnt_r <= val_i;
      end else if (cnt_r != '0) begin
         cnt_r <= cnt_r - W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero_o = (cnt_r == '0);

endmodule

// File: rtl/clap_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// clap_pattern_ctrl
//   Groups single-cycle clap pulses into single/double/triple patterns using a
//   refractory window after each accepted clap and an idle gap that closes the
//   group. Each group produces one command over a valid/ready handshake; a
//   running total of accepted claps is kept.
//   Ports:
//     clk_i        in   1      system clock
//     rst_i        in   1      asynchronous active-high reset
//     en_i         in   1      1 = accept claps; 0 = abandon open group
//     clr_i        in   1      synchronous clear of clap_cnt_o (wins over a clap)
//     clap_i       in   1      single-cycle clap pulse (already synchronised)
//     cmd_valid_o  out  1      command available
//     cmd_ready_i  in   1      consumer accepts command
//     cmd_code_o   out  2      1 single, 2 double, 3 triple; 0 when not valid
//     clap_cnt_o   out  CNT_W  accepted-clap total, wraps
//     busy_o       out  1      FSM not in IDLE
//     drop_o       out  1      one-cycle pulse: clap arrived while in EMIT
// -----------------------------------------------------------------------------
module clap_pattern_ctrl
   import clap_pattern_ctrl_pkg::*;
#(
   parameter int REFRACT_CYC = REFRACT_CYC_DFLT,
   parameter int GAP_CYC     = GAP_CYC_DFLT,
   parameter int CNT_W       = CNT_W_DFLT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             clap_i,
   output logic             cmd_valid_o,
   input  logic             cmd_ready_i,
   output logic [1:0]       cmd_code_o,
   output logic [CNT_W-1:0] clap_cnt_o,
   output logic             busy_o,
   output logic             drop_o
);

   localparam int TMR_W = timer_width(REFRACT_CYC, GAP_CYC);
   localparam logic [TMR_W-1:0] REFRACT_LD = TMR_W'(REFRACT_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(GAP_CYC - 1);

   state_t           state_r;
   logic [1:0]       grp_r;
   logic             cmd_valid_r;
   logic [1:0]       cmd_code_r;
   logic [CNT_W-1:0] clap_cnt_r;
   logic             busy_r;
   logic             drop_r;

   logic             clap_acc_s;
   logic             tmr_load_s;
   logic [TMR_W-1:0] tmr_val_s;
   logic             tmr_zero_s;

   // A clap only counts when enabled and the FSM is open for a new clap.
   assign clap_acc_s = clap_i & en_i &
                       ((state_r == ST_IDLE) | (state_r == ST_WAIT_GAP));

   // Timer reload decisions, aligned with the FSM transitions below.
   always_comb begin
      tmr_load_s = 1'b0;
      tmr_val_s  = REFRACT_LD;
      case (state_r)
         ST_IDLE: begin
            if (clap_acc_s) begin
               tmr_load_s = 1'b1;
               tmr_val_s  = REFRACT_LD;
            end else begin
               tmr_load_s = 1'b0;
            end
         end
         ST_REFRACT: begin
            if (en_i && tmr_zero_s) begin
               tmr_load_s = 1'b1;
               tmr_val_s  = GAP_LD;
            end else begin
               tmr_load_s = 1'b0;
            end
         end
         ST_WAIT_GAP: begin
            // The third clap goes straight to EMIT, so no refractory reload.
            if (clap_acc_s && (grp_r != CMD_DOUBLE)) begin
               tmr_load_s = 1'b1;
               tmr_val_s  = REFRACT_LD;
            end else begin
               tmr_load_s = 1'b0;
            end
         end
         default: begin
            tmr_load_s = 1'b0;
         end
      endcase
   end

   clap_pattern_ctrl_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (tmr_load_s),
      .val_i  (tmr_val_s),
      .zero_o (tmr_zero_s)
   );

   // Pattern FSM with group count and registered handshake/status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         grp_r       <= CMD_NONE;
         cmd_valid_r <= 1'b0;
         cmd_code_r  <= CMD_NONE;
         busy_r      <= 1'b0;
         drop_r      <= 1'b0;
      end else begin
         drop_r <= (state_r == ST_EMIT) & clap_i;
         case (state_r)
            ST_IDLE: begin
               if (clap_acc_s) begin
                  state_r <= ST_REFRACT;
                  grp_r   <= CMD_SINGLE;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REFRACT: begin
               if (!en_i) begin
                  state_r <= ST_IDLE;
                  grp_r   <= CMD_NONE;
                  busy_r  <= 1'b0;
               end else if (tmr_zero_s) begin
                  state_r <= ST_WAIT_GAP;
               end else begin
                  state_r <= ST_REFRACT;
               end
            end
            ST_WAIT_GAP: begin
               if (!en_i) begin
                  state_r <= ST_IDLE;
                  grp_r   <= CMD_NONE;
                  busy_r  <= 1'b0;
               end else if (clap_acc_s) begin
                  if (grp_r == CMD_DOUBLE) begin
                     state_r     <= ST_EMIT;
                     grp_r       <= CMD_TRIPLE;
                     cmd_valid_r <= 1'b1;
                     cmd_code_r  <= CMD_TRIPLE;
                  end else begin
                     state_r <= ST_REFRACT;
                     grp_r   <= CMD_DOUBLE;
                  end
               end else if (tmr_zero_s) begin
                  state_r     <= ST_EMIT;
                  cmd_valid_r <= 1'b1;
                  cmd_code_r  <= grp_r;
               end else begin
                  state_r <= ST_WAIT_GAP;
               end
            end
            ST_EMIT: begin
               // cmd_valid_r is always high in EMIT, so ready alone completes the transfer.
               if (cmd_ready_i) begin
                  state_r     <= ST_IDLE;
                  grp_r       <= CMD_NONE;
                  cmd_valid_r <= 1'b0;
                  cmd_code_r  <= CMD_NONE;
                  busy_r      <= 1'b0;
               end else begin
                  state_r <= ST_EMIT;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               grp_r       <= CMD_NONE;
               cmd_valid_r <= 1'b0;
               cmd_code_r  <= CMD_NONE;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Accepted-clap total; clear takes priority over a simultaneous clap.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clap_cnt_r <= '0;
      end else if (clr_i) begin
         clap_cnt_r <= '0;
      end else if (clap_acc_s) begin
         clap_cnt_r <= clap_cnt_r + CNT_W'(1'b1);
      end else begin
         clap_cnt_r <= clap_cnt_r;
      end
   end

   assign cmd_valid_o = cmd_valid_r;
   assign cmd_code_o  = cmd_code_r;
   assign clap_cnt_o  = clap_cnt_r;
   assign busy_o      = busy_r;
   assign drop_o      = drop_r;

endmodule

// File: tb/tb_clap_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clap_pattern_ctrl
//   Directed bench for clap_pattern_ctrl (REFRACT_CYC=4, GAP_CYC=10, CNT_W=4).
//   A deadline-based reference model (cycle numbers of reopen / close events)
//   is compared against the DUT on every cycle; directed scenarios add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_clap_pattern_ctrl;

   localparam int R  = 4;
   localparam int G  = 10;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic          clap = 1'b0;
   logic          ready = 1'b0;
   logic          cmd_valid;
   logic [1:0]    cmd_code;
   logic [CW-1:0] clap_cnt;
   logic          busy;
   logic          drop;

   int errors = 0;
   int checks = 0;

   clap_pattern_ctrl #(
      .REFRACT_CYC (R),
      .GAP_CYC     (G),
      .CNT_W       (CW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .clr_i       (clr),
      .clap_i      (clap),
      .cmd_valid_o (cmd_valid),
      .cmd_ready_i (ready),
      .cmd_code_o  (cmd_code),
      .clap_cnt_o  (clap_cnt),
      .busy_o      (busy),
      .drop_o      (drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A group is described by its size, the first cycle a new clap is accepted,
   // and the cycle on which the command appears if no further clap arrives.
   int cyc = 0;
   int m_grp = 0;
   bit m_emit = 1'b0;
   int m_accept_from = 0;
   int m_close_at = 0;
   int m_cnt = 0;
   bit m_drop = 1'b0;

   always @(posedge clk) begin
      bit acc;
      bit nd;
      acc = 1'b0;
      if (rst) begin
         m_grp = 0; m_emit = 1'b0; m_cnt = 0; m_drop = 1'b0;
      end else begin
         nd = m_emit && clap;
         if (m_emit) begin
            if (ready) begin
               m_emit = 1'b0;
               m_grp  = 0;
            end
         end else if (m_grp > 0) begin
            if (!en) begin
               m_grp = 0;
            end else if (clap && cyc >= m_accept_from) begin
               acc = 1'b1;
               m_grp++;
               if (m_grp == 3) begin
                  m_emit = 1'b1;
               end else begin
                  m_accept_from = cyc + R + 1;
                  m_close_at    = cyc + R + G + 1;
               end
            end else if (cyc + 1 == m_close_at) begin
               m_emit = 1'b1;
            end
         end else if (en && clap) begin
            acc = 1'b1;
            m_grp = 1;
            m_accept_from = cyc + R + 1;
            m_close_at    = cyc + R + G + 1;
         end
         if (clr) m_cnt = 0;
         else if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
         m_drop = nd;
      end
      cyc++;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("cmp_valid", int'(cmd_valid), int'(m_emit));
         chk("cmp_code",  int'(cmd_code),  m_emit ? m_grp : 0);
         chk("cmp_busy",  int'(busy),      (m_emit || m_grp > 0) ? 1 : 0);
         chk("cmp_cnt",   int'(clap_cnt),  m_cnt);
         chk("cmp_drop",  int'(drop),      int'(m_drop));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input logic c, input logic e, input logic r, input logic k);
      clap = c; en = e; ready = r; clr = k;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_code",  int'(cmd_code),  0);
      chk("rst_cnt",   int'(clap_cnt),  0);
      chk("rst_busy",  int'(busy),      0);
      chk("rst_drop",  int'(drop),      0);
      rst = 1'b0;
   endtask

   // Returns cycles from c0 until cmd_valid is seen, or -1 on timeout.
   task automatic wait_valid(input int c0, input logic r, output int dly);
      dly = -1;
      for (int i = 0; i < 60; i++) begin
         if (cmd_valid) begin
            dly = cyc - c0;
            break;
         end
         tick(1'b0, 1'b1, r, 1'b0);
      end
      if (dly < 0) $display("FAIL wait_valid: actual=timeout required=valid within 60 cycles");
   endtask

   initial begin
      int c0;
      int d;
      int nv;
      int nd;

      @(negedge clk);
      #1;

      // Lone clap: command at cycle R+G+1 = 15, gone at 16.
      do_reset();
      c0 = cyc;
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      wait_valid(c0, 1'b1, d);
      chk("t1_latency", d, 15);
      chk("t1_code", int'(cmd_code), 1);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t1_valid_off", int'(cmd_valid), 0);
      chk("t1_busy_off", int'(busy), 0);
      chk("t1_cnt", int'(clap_cnt), 1);

      // Triple at 0,6,12: command one cycle after the third clap.
      do_reset();
      c0 = cyc;
      for (int k = 0; k <= 12; k++) begin
         tick((k % 6 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0);
      end
      wait_valid(c0, 1'b1, d);
      chk("t2_latency", d, 13);
      chk("t2_code", int'(cmd_code), 3);
      chk("t2_cnt", int'(clap_cnt), 3);
      tick(1'b0, 1'b1, 1'b1, 1'b0);

      // Claps inside the refractory window are ignored, not dropped.
      do_reset();
      c0 = cyc;
      nd = 0;
      for (int k = 0; k < 4; k++) begin
         tick((k == 0 || k == 2 || k == 3) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0);
         if (drop) nd++;
      end
      wait_valid(c0, 1'b1, d);
      chk("t3_latency", d, 15);
      chk("t3_code", int'(cmd_code), 1);
      chk("t3_cnt", int'(clap_cnt), 1);
      chk("t3_no_drop", nd, 0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);

      // Double (second clap on the first open cycle), stalled consumer, clap during EMIT.
      do_reset();
      nv = 0;
      nd = 0;
      for (int k = 0; k < 30; k++) begin
         tick((k == 0 || k == 5 || k == 25) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
         if (cmd_valid) begin
            nv++;
            chk("t4_code_hold", int'(cmd_code), 2);
         end
         if (drop) nd++;
      end
      chk("t4_valid_cycles", nv, 11);
      chk("t4_drop_pulses", nd, 1);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t4_valid_off", int'(cmd_valid), 0);
      chk("t4_cnt", int'(clap_cnt), 2);

      // 16 single groups wrap the 4-bit total; clear beats a same-cycle clap.
      do_reset();
      for (int g = 0; g < 16; g++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b0);
         repeat (16) tick(1'b0, 1'b1, 1'b1, 1'b0);
         if (g == 14) chk("t5_cnt_15", int'(clap_cnt), 15);
      end
      chk("t5_cnt_wrap", int'(clap_cnt), 0);
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (16) tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t5_cnt_1", int'(clap_cnt), 1);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      chk("t5_clr_wins", int'(clap_cnt), 0);
      chk("t5_clr_fsm", int'(busy), 1);
      repeat (16) tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t5_idle", int'(busy), 0);

      // en_i dropped in WAIT_GAP abandons the group.
      do_reset();
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (6) tick(1'b0, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6_abandon_busy", int'(busy), 0);
      nv = 0;
      repeat (30) begin
         tick(1'b0, 1'b1, 1'b1, 1'b0);
         if (cmd_valid) nv++;
      end
      chk("t6_no_cmd", nv, 0);

      // Reset while a command is pending discards it immediately.
      c0 = cyc;
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      wait_valid(c0, 1'b0, d);
      chk("t7_latency", d, 15);
      rst = 1'b1;
      #1;
      chk("t7_rst_valid", int'(cmd_valid), 0);
      chk("t7_rst_code",  int'(cmd_code),  0);
      chk("t7_rst_busy",  int'(busy),      0);
      chk("t7_rst_cnt",   int'(clap_cnt),  0);
      chk("t7_rst_drop",  int'(drop),      0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      nv = 0;
      repeat (5) begin
         tick(1'b0, 1'b1, 1'b1, 1'b0);
         if (cmd_valid || busy) nv++;
      end
      chk("t7_stays_idle", nv, 0);

      clap = 1'b0; en = 1'b0; ready = 1'b0; clr = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
